// File: rtl/algo_3ror1w_refr_sched.sv
// Refresh scheduler for the 3-read-or-1-write memory: issues periodic refresh
// pulses, lets the host postpone up to MAXPOST of them, and forces one when the backlog is full.
module algo_3ror1w_refr_sched #(
  parameter int REFFREQ = 6,
  parameter int REFFRHF = 0,
  parameter int BITFREQ = 8,
  parameter int MAXPOST = 4,
  parameter int BITPOST = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               ready,
  input  logic               hold,
  output logic               refr,
  output logic [BITPOST-1:0] pend_cnt,
  output logic               forced,
  output logic               err_ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [BITFREQ-1:0] LAST_LO  = BITFREQ'(REFFREQ - 1);
  localparam logic [BITFREQ-1:0] LAST_HI  = BITFREQ'(REFFREQ);
  localparam logic [BITPOST-1:0] PEND_MAX = BITPOST'(MAXPOST);

  state_t             state;
  logic [BITFREQ-1:0] timer;
  logic               phase;

  logic               go;
  logic [BITFREQ-1:0] last;
  logic               expire;
  logic               at_max;
  logic               issue;
  logic               ovf;

  // Saturating backlog update: an expire and an issue in the same cycle cancel.
  function automatic logic [BITPOST-1:0] pend_next(input logic [BITPOST-1:0] cur,
                                                   input logic inc,
                                                   input logic dec);
    if (inc && !dec)
      pend_next = (cur == PEND_MAX) ? cur : cur + 1'b1;
    else if (dec && !inc)
      pend_next = cur - 1'b1;
    else
      pend_next = cur;
  endfunction

  always_comb begin
    go     = enable && ready;
    last   = (REFFRHF != 0 && phase) ? LAST_HI : LAST_LO;
    expire = (state == RUN) && (timer == last);
    at_max = (pend_cnt == PEND_MAX);
    // refr is still high in the cycle after an issue, which keeps pulses apart
    issue  = (state == RUN) && (pend_cnt != '0) && !refr && (!hold || at_max);
    ovf    = expire && at_max && !issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      phase    <= 1'b0;
      pend_cnt <= '0;
      refr     <= 1'b0;
      forced   <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer    <= '0;
          phase    <= 1'b0;
          pend_cnt <= '0;
          refr     <= 1'b0;
          forced   <= 1'b0;
          if (go)
            state <= RUN;
        end
        RUN: begin
          if (!go) begin
            // Memory re-initialises itself after losing ready; owed refreshes are dropped.
            state    <= IDLE;
            timer    <= '0;
            phase    <= 1'b0;
            pend_cnt <= '0;
            refr     <= 1'b0;
            forced   <= 1'b0;
          end else begin
            timer    <= expire ? '0 : timer + 1'b1;
            if (REFFRHF != 0 && expire)
              phase <= ~phase;
            pend_cnt <= pend_next(pend_cnt, expire, issue);
            refr     <= issue;
            forced   <= issue && hold;
            if (ovf)
              err_ovf <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_algo_3ror1w_refr_sched.sv
// Bench for algo_3ror1w_refr_sched: four parameter sets driven side by side,
// checked against fixed timelines and a cycle-count based reference model.
module tb_algo_3ror1w_refr_sched;

  localparam int N = 4;
  localparam int RF[N] = '{6, 6, 2, 3};
  localparam int RH[N] = '{0, 1, 0, 1};
  localparam int MP[N] = '{4, 4, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en[N], rdy[N], hld[N];
  logic       refr_o[N], forced_o[N], err_o[N];
  logic [2:0] pend_o[N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    algo_3ror1w_refr_sched #(
      .REFFREQ(RF[g]), .REFFRHF(RH[g]), .BITFREQ(8), .MAXPOST(MP[g]), .BITPOST(3)
    ) dut (
      .clk(clk), .rst(rst), .enable(en[g]), .ready(rdy[g]), .hold(hld[g]),
      .refr(refr_o[g]), .pend_cnt(pend_o[g]), .forced(forced_o[g]), .err_ovf(err_o[g])
    );
  end

  // Reference model: expiries tracked as absolute cycle numbers within the run,
  // owed refreshes as a plain integer.
  int   m_pend[N], m_cnt[N], m_next[N], m_k[N];
  logic m_run[N], m_refr[N], m_forced[N], m_err[N];

  always @(posedge clk or negedge rst) begin
    bit e;
    bit s;
    int np;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= 0; m_cnt[i] <= 0; m_next[i] <= 0; m_k[i] <= 0;
        m_run[i] <= 0; m_refr[i] <= 0; m_forced[i] <= 0; m_err[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!m_run[i]) begin
          m_pend[i] <= 0; m_refr[i] <= 0; m_forced[i] <= 0;
          if (en[i] && rdy[i]) begin
            m_run[i] <= 1; m_cnt[i] <= 0; m_next[i] <= RF[i] - 1; m_k[i] <= 0;
          end
        end else if (!(en[i] && rdy[i])) begin
          m_run[i] <= 0; m_pend[i] <= 0; m_refr[i] <= 0; m_forced[i] <= 0;
        end else begin
          e  = (m_cnt[i] == m_next[i]);
          s  = (m_pend[i] > 0) && !m_refr[i] && (!hld[i] || m_pend[i] == MP[i]);
          np = m_pend[i] + (e ? 1 : 0) - (s ? 1 : 0);
          if (np > MP[i]) begin
            np = MP[i];
            m_err[i] <= 1;
          end
          m_pend[i]   <= np;
          m_refr[i]   <= s;
          m_forced[i] <= s && hld[i];
          m_cnt[i]    <= m_cnt[i] + 1;
          if (e) begin
            m_k[i]    <= m_k[i] + 1;
            m_next[i] <= m_next[i] + RF[i] + ((RH[i] != 0 && ((m_k[i] + 1) % 2) == 1) ? 1 : 0);
          end
        end
      end
    end
  end

  // Reset everything, enable only instance idx; returns at the start of its cycle 0.
  task automatic start(input int idx, input logic h);
    for (int i = 0; i < N; i++) begin
      en[i] = 0; rdy[i] = 0; hld[i] = 0;
    end
    en[idx] = 1; rdy[idx] = 1; hld[idx] = h;
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++) begin
      en[i] = 1; rdy[i] = 1; hld[i] = 0;
    end
    rst = 0;
    #12;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if ({refr_o[i], forced_o[i], err_o[i], pend_o[i]} !== 6'b0)
        $display("FAIL reset inst%0d: refr=%b forced=%b err=%b pend=%0d, required all 0",
                 i, refr_o[i], forced_o[i], err_o[i], pend_o[i]);
      if ({refr_o[i], forced_o[i], err_o[i], pend_o[i]} !== 6'b0) n_fail++;
    end
  endtask

  task automatic test_period;
    logic       er;
    logic [2:0] ep;
    start(0, 0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      er = (c == 7 || c == 13 || c == 19);
      ep = (c == 6 || c == 12 || c == 18) ? 3'd1 : 3'd0;
      n_checks++;
      if (refr_o[0] !== er) begin
        n_fail++; $display("FAIL period_refr c=%0d: got %b, required %b", c, refr_o[0], er);
      end
      n_checks++;
      if (pend_o[0] !== ep) begin
        n_fail++; $display("FAIL period_pend c=%0d: got %0d, required %0d", c, pend_o[0], ep);
      end
      n_checks++;
      if (forced_o[0] !== 1'b0 || err_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL period_flags c=%0d: forced=%b err=%b, required 0 0", c, forced_o[0], err_o[0]);
      end
    end
  endtask

  task automatic test_half_period;
    logic       er;
    logic [2:0] ep;
    start(1, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      er = (c == 7 || c == 14 || c == 20 || c == 27);
      ep = (c == 6 || c == 13 || c == 19 || c == 26) ? 3'd1 : 3'd0;
      n_checks++;
      if (refr_o[1] !== er) begin
        n_fail++; $display("FAIL half_refr c=%0d: got %b, required %b", c, refr_o[1], er);
      end
      n_checks++;
      if (pend_o[1] !== ep) begin
        n_fail++; $display("FAIL half_pend c=%0d: got %0d, required %0d", c, pend_o[1], ep);
      end
    end
  endtask

  task automatic test_hold_max;
    start(0, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if (refr_o[0] !== m_refr[0] || forced_o[0] !== m_forced[0] || pend_o[0] !== 3'(m_pend[0])) begin
        n_fail++;
        $display("FAIL holdmax_model c=%0d: refr=%b forced=%b pend=%0d, required %b %b %0d",
                 c, refr_o[0], forced_o[0], pend_o[0], m_refr[0], m_forced[0], m_pend[0]);
      end
      n_checks++;
      if (pend_o[0] > 3'd4 || err_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL holdmax_bound c=%0d: pend=%0d err=%b, required <=4 and 0", c, pend_o[0], err_o[0]);
      end
      if (c == 24) begin
        n_checks++;
        if (pend_o[0] !== 3'd4) begin
          n_fail++; $display("FAIL holdmax_full c=24: pend=%0d, required 4", pend_o[0]);
        end
      end
      if (c == 25) begin
        n_checks++;
        if (refr_o[0] !== 1'b1 || forced_o[0] !== 1'b1) begin
          n_fail++; $display("FAIL holdmax_forced c=25: refr=%b forced=%b, required 1 1", refr_o[0], forced_o[0]);
        end
      end
    end
  endtask

  task automatic test_min_period;
    start(2, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if (refr_o[2] !== m_refr[2] || forced_o[2] !== m_forced[2] ||
          pend_o[2] !== 3'(m_pend[2]) || err_o[2] !== m_err[2]) begin
        n_fail++;
        $display("FAIL minper c=%0d: refr=%b forced=%b pend=%0d err=%b, required %b %b %0d %b",
                 c, refr_o[2], forced_o[2], pend_o[2], err_o[2],
                 m_refr[2], m_forced[2], m_pend[2], m_err[2]);
      end
      n_checks++;
      if (pend_o[2] > 3'd1) begin
        n_fail++; $display("FAIL minper_bound c=%0d: pend=%0d, required <=1", c, pend_o[2]);
      end
      if (c == 20) hld[2] = 0;
    end
  endtask

  task automatic test_ready_drop;
    logic [2:0] ep;
    start(0, 1);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ep = (c < 6) ? 3'd0 : (c < 12) ? 3'd1 : (c < 18) ? 3'd2 : (c < 20) ? 3'd3 :
           (c < 27) ? 3'd0 : 3'd1;
      n_checks++;
      if (pend_o[0] !== ep || refr_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_drop c=%0d: pend=%0d refr=%b, required %0d 0", c, pend_o[0], refr_o[0], ep);
      end
      if (c == 19) rdy[0] = 0;
      if (c == 20) rdy[0] = 1;
    end
  endtask

  task automatic test_async_reset;
    start(0, 0);
    for (int c = 0; c < 8; c++) @(negedge clk);
    n_checks++;
    if (refr_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL async_pre c=7: refr=%b, required 1", refr_o[0]);
    end
    #1 rst = 0;
    #1;
    n_checks++;
    if ({refr_o[0], forced_o[0], err_o[0], pend_o[0]} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: refr=%b forced=%b err=%b pend=%0d, required all 0",
               refr_o[0], forced_o[0], err_o[0], pend_o[0]);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_random;
    start(3, 0);
    for (int i = 0; i < N; i++) begin
      en[i] = 1; rdy[i] = 1;
    end
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (refr_o[i] !== m_refr[i] || forced_o[i] !== m_forced[i] ||
            pend_o[i] !== 3'(m_pend[i]) || err_o[i] !== m_err[i]) begin
          n_fail++;
          $display("FAIL random inst%0d c=%0d: refr=%b forced=%b pend=%0d err=%b, required %b %b %0d %b",
                   i, c, refr_o[i], forced_o[i], pend_o[i], err_o[i],
                   m_refr[i], m_forced[i], m_pend[i], m_err[i]);
        end
        en[i]  = ($urandom_range(0, 19) != 0);
        rdy[i] = ($urandom_range(0, 19) != 0);
        hld[i] = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      en[i] = 0; rdy[i] = 0; hld[i] = 0;
    end
    test_reset;
    test_period;
    test_half_period;
    test_hold_max;
    test_min_period;
    test_ready_drop;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
